// File: rtl/gemv_array_top.sv
// gemv_array_top
//   Matrix-vector multiply engine: O = A * W for an SZ x SZ matrix A and an
//   SZ-element vector W. The engine is a linear array of SZ multiply-accumulate
//   PEs. PE i owns row i of A and walks the columns one per cycle.
//   A and W are latched on the start strobe, so the caller may change them
//   immediately afterwards. The arithmetic is unsigned. Each product is
//   truncated to DW bits and the accumulation wraps modulo 2^DW.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   en_i     start strobe, honoured only in IDLE
//   A        matrix operand, row-major: A[i*SZ+j] is row i, column j
//   W        vector operand, W[j]
//   O        result vector; holds the last result until the next DONE or reset
//   valid_o  one-cycle pulse marking a fresh O
//
// State  | meaning
// IDLE   | waiting for en_i; operands are latched on the start edge
// RUN    | one column k per cycle; every PE accumulates A[i][k]*W[k]
// DONE   | accumulators are copied to O and valid_o pulses

module gemv_array_top #(
   parameter int DW = 16,
   parameter int SZ = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en_i,
   input  logic [DW-1:0] A [SZ*SZ],
   input  logic [DW-1:0] W [SZ],
   output logic [DW-1:0] O [SZ],
   output logic          valid_o
);

   localparam int KW = (SZ > 1) ? $clog2(SZ) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(SZ - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state;
   logic [KW-1:0] k;
   logic          start;

   logic [DW-1:0] a_r [SZ*SZ];
   logic [DW-1:0] w_r [SZ];

   assign start = (state == IDLE) && en_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         k       <= '0;
         valid_o <= 1'b0;
      end else begin
         valid_o <= 1'b0;
         case (state)
            IDLE: begin
               if (en_i) begin
                  state <= RUN;
                  k     <= '0;
               end
            end
            RUN: begin
               if (k == K_LAST) begin
                  state <= DONE;
                  k     <= '0;
               end else begin
                  k <= k + KW'(1);
               end
            end
            DONE: begin
               valid_o <= 1'b1;
               state   <= IDLE;
            end
            default: begin
               state <= IDLE;
               k     <= '0;
            end
         endcase
      end
   end

   // The operand copies carry no reset. Every computation reloads them first.
   always_ff @(posedge clk) begin
      if (start) begin
         a_r <= A;
         w_r <= W;
      end
   end

   for (genvar i = 0; i < SZ; i++) begin : g_pe
      logic [DW-1:0] row [SZ];
      logic [DW-1:0] prod;
      logic [DW-1:0] acc;
      logic [DW-1:0] o_q;

      for (genvar j = 0; j < SZ; j++) begin : g_row
         assign row[j] = a_r[i*SZ + j];
      end

      // A DW-wide context keeps only the low DW bits of the product.
      assign prod = row[k] * w_r[k];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            acc <= '0;
            o_q <= '0;
         end else begin
            if (start) begin
               acc <= '0;
            end else if (state == RUN) begin
               acc <= acc + prod;
            end
            if (state == DONE) begin
               o_q <= acc;
            end
         end
      end

      assign O[i] = o_q;
   end

endmodule

// File: tb/tb_gemv_array_top.sv
module tb_gemv_array_top;

   localparam int DW = 16;
   localparam int SZ = 3;

   typedef logic [SZ*SZ-1:0][DW-1:0] mat_t;
   typedef logic [SZ-1:0][DW-1:0]    vec_t;

   typedef struct packed {
      mat_t a;
      vec_t w;
      vec_t o;
   } tv_t;

   logic          clk;
   logic          rst_n;
   logic          en_i;
   logic [DW-1:0] A [SZ*SZ];
   logic [DW-1:0] W [SZ];
   logic [DW-1:0] O [SZ];
   logic          valid_o;

   int checks   = 0;
   int failures = 0;

   vec_t exp_q [$];
   tv_t  tv [5];

   gemv_array_top #(.DW(DW), .SZ(SZ)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en_i),
      .A       (A),
      .W       (W),
      .O       (O),
      .valid_o (valid_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input int unsigned act, input int unsigned req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
      end
   endtask

   function automatic vec_t model(input mat_t a, input vec_t w);
      vec_t r;
      for (int i = 0; i < SZ; i++) begin
         r[i] = '0;
         for (int j = 0; j < SZ; j++) begin
            logic [DW-1:0] p;
            p    = a[i*SZ + j] * w[j];
            r[i] = r[i] + p;
         end
      end
      return r;
   endfunction

   task automatic drive_ops(input mat_t a, input vec_t w);
      for (int i = 0; i < SZ*SZ; i++) A[i] = a[i];
      for (int j = 0; j < SZ; j++) W[j] = w[j];
   endtask

   task automatic scramble();
      for (int i = 0; i < SZ*SZ; i++) A[i] = DW'($urandom);
      for (int j = 0; j < SZ; j++) W[j] = DW'($urandom);
   endtask

   task automatic check_o(input string nm, input vec_t req);
      for (int i = 0; i < SZ; i++) check($sformatf("%s O[%0d]", nm, i), O[i], req[i]);
   endtask

   // Runs one operation from a negedge. It pushes the expected result, waits
   // with a bound for valid_o, and checks the latency, the data and the pulse
   // width. The optional poke pulses en_i with fresh operands during RUN.
   task automatic run_op(input string nm, input mat_t a, input vec_t w, input bit poke);
      int   n;
      bit   seen;
      int   extra;
      vec_t req;
      drive_ops(a, w);
      en_i = 1'b1;
      exp_q.push_back(model(a, w));
      @(posedge clk);
      @(negedge clk);
      en_i = 1'b0;
      scramble();
      n    = 0;
      seen = 1'b0;
      while (n < 10 && !seen) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         if (poke && n == 1) begin
            en_i = 1'b1;
            scramble();
         end else begin
            en_i = 1'b0;
         end
         if (valid_o) seen = 1'b1;
      end
      en_i = 1'b0;
      req = exp_q.pop_front();
      if (!seen) begin
         checks++;
         failures++;
         $display("FAIL %s timeout: valid_o never rose within 10 cycles", nm);
      end else begin
         check({nm, " latency"}, n, SZ + 1);
         check_o(nm, req);
         @(posedge clk);
         @(negedge clk);
         check({nm, " pulse width"}, valid_o, 0);
         extra = 0;
         for (int c = 0; c < SZ + 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (valid_o) extra++;
         end
         check({nm, " extra pulses"}, extra, 0);
         check_o({nm, " hold"}, req);
      end
   endtask

   initial begin
      mat_t ra;
      vec_t rw;
      int   hits;
      int   pos [$];

      tv[0] = '{a: {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1},
                w: {16'd3, 16'd2, 16'd1}, o: {16'd50, 16'd32, 16'd14}};
      tv[1] = '{a: {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1},
                w: {16'd6, 16'd4, 16'd2}, o: {16'd100, 16'd64, 16'd28}};
      tv[2] = '{a: {16'd0, 16'd0, 16'd0, 16'd6, 16'd4, 16'd2, 16'd5, 16'd3, 16'd1},
                w: {16'd3, 16'd2, 16'd1}, o: {16'd0, 16'd28, 16'd22}};
      tv[3] = '{a: {16'd0, 16'd6, 16'd3, 16'd0, 16'd5, 16'd2, 16'd0, 16'd4, 16'd1},
                w: {16'd0, 16'd2, 16'd1}, o: {16'd15, 16'd12, 16'd9}};
      tv[4] = '{a: {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'hFFFF},
                w: {16'd0, 16'd0, 16'hFFFF}, o: {16'd0, 16'd0, 16'd1}};

      rst_n = 1'b0;
      en_i  = 1'b0;
      drive_ops('0, '0);
      #12;
      rst_n = 1'b1;
      @(negedge clk);

      // Put a nonzero result in O, then assert reset between clock edges.
      run_op("seed", tv[0].a, tv[0].w, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_o("async reset", '0);
      check("async reset valid_o", valid_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      hits = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (valid_o) hits++;
      end
      check("idle valid_o", hits, 0);

      // The table holds hand-computed expectations. Check them against the model first.
      for (int t = 0; t < 5; t++) begin
         check($sformatf("table%0d model", t), model(tv[t].a, tv[t].w), tv[t].o);
         run_op($sformatf("table%0d", t), tv[t].a, tv[t].w, 1'b0);
      end

      // Fresh operands and en_i during RUN must not disturb the result.
      run_op("poke during run", tv[0].a, tv[0].w, 1'b1);

      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < SZ*SZ; i++) ra[i] = DW'($urandom);
         for (int j = 0; j < SZ; j++) rw[j] = DW'($urandom);
         run_op($sformatf("random%0d", r), ra, rw, 1'b0);
      end

      // Reset during RUN aborts the operation, and no valid_o follows.
      drive_ops(tv[1].a, tv[1].w);
      en_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en_i = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_o("reset in run", '0);
      @(negedge clk);
      rst_n = 1'b1;
      hits = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         @(negedge clk);
         if (valid_o) hits++;
      end
      check("reset in run valid_o", hits, 0);
      check_o("reset in run after", '0);

      // Holding en_i high restarts at the first IDLE edge after each DONE.
      drive_ops(tv[0].a, tv[0].w);
      en_i = 1'b1;
      exp_q.push_back(tv[0].o);
      exp_q.push_back(tv[0].o);
      @(posedge clk);
      @(negedge clk);
      for (int n = 1; n <= 2*(SZ + 2) + 1; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (valid_o) begin
            pos.push_back(n);
            if (exp_q.size() > 0) check_o($sformatf("held en pulse%0d", pos.size()), exp_q.pop_front());
         end
      end
      en_i = 1'b0;
      check("held en pulse count", pos.size(), 2);
      if (pos.size() == 2) begin
         check("held en first", pos[0], SZ + 1);
         check("held en spacing", pos[1] - pos[0], SZ + 2);
      end
      exp_q.delete();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
